regfile_wr_arbiter: RTL
=======================

Name: regfile_wr_arbiter

Overview:
- Shares the register file's single write port between NREQ requesters using round-robin arbitration.
- Registers the winning request into one write transaction per cycle: wr_en_o, plus wr_addr_o feeding the destination-select decoder, plus wr_data_o.
- Returns a one-cycle acknowledge to the winning requester.
- Keeps a saturating count of contention cycles for performance debug.

Parameters:
- NREQ, 4: number of requesters; legal values 2..8.
- DW, 16: register data width.
- AW, 3: register address width; 8 registers.
- CW, 8: contention counter width.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- req_i  input  NREQ  per-requester write request.
- addr_i  input  NREQ*AW  packed destination addresses; requester k occupies bits [k*AW +: AW].
- data_i  input  NREQ*DW  packed write data; requester k occupies bits [k*DW +: DW].
- stall_i  input  1  register file busy; blocks new grants.
- ack_o  output  NREQ  one-hot grant pulse, registered.
- wr_en_o  output  1  register file write enable, registered.
- wr_addr_o  output  AW  destination register index, registered; drives the decoder input.
- wr_data_o  output  DW  write data, registered.
- contention_o  output  CW  saturating count of contention cycles.

Behaviour:
Reset:
- rst_i asserted clears everything immediately, independent of clk_i: ack_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, contention_o=0, round-robin pointer ptr=0.
- Reset mid-transaction discards the transaction; no write is issued and no ack is issued.

Requester protocol:
- Requester k raises req_i[k] and holds addr/data stable until it sees ack_o[k]=1.
- In the ack cycle it may drop req_i[k] or present a new request.

Eligibility (combinational):
- elig = req_i & ~ack_o. A requester being acked this cycle is excluded.
- Consequence: one requester alone gets at most one grant every 2 cycles.

Arbitration:
- Round-robin search over elig starting at index ptr, ascending, wrapping NREQ-1 -> 0.
- The first set bit is the winner w.

Clock edge, stall_i=0 and elig!=0:
- wr_en_o<=1, wr_addr_o<=addr_i[w], wr_data_o<=data_i[w], ack_o<=onehot(w).
- ptr<=(w+1) mod NREQ.

Clock edge, stall_i=1 or elig==0:
- wr_en_o<=0 and ack_o<=0.
- wr_addr_o, wr_data_o and ptr hold their values.
- stall_i does not cancel a write already on wr_en_o; it only blocks the next grant.

Latency and throughput:
- 1 cycle from eligible request to wr_en_o/ack_o.
- Maximum throughput is 1 write per cycle when two or more requesters alternate.

Contention counter:
- Increments on each edge where stall_i=0 and popcount(elig)>=2.
- Saturates at 2^CW-1; never wraps.

Invariants and boundaries:
- ack_o is zero or one-hot, and ack_o!=0 exactly when wr_en_o=1.
- Two requesters targeting the same address are serialized in round-robin order; the last write wins in the register file.
- Arbitration ignores addresses; there is no address-based blocking.

Test Plan:
- Reset: drive rst_i=1 mid-cycle with req_i=4'b1111 -> all outputs 0 immediately, with no edge needed; after release, the first grant goes to requester 0.
- Single requester: req_i=4'b0100, addr=3'd5, data=16'hBEEF, held -> wr_en_o=1, wr_addr_o=5, wr_data_o=BEEF, ack_o=4'b0100 on cycles 1, 3, 5, ...; wr_en_o=0 on cycles 2, 4, ...
- Round-robin fairness: req_i=4'b1111 held, each requester at a distinct address -> ack_o sequence 0001, 0010, 0100, 1000, 0001, ...; wr_en_o=1 every cycle; contention_o increments by 1 per cycle.
- Pointer wrap: ptr=3 after a grant to requester 2, then req_i=4'b1001 -> next ack 1000, then 0001.
- Stall: req_i=4'b0011 with stall_i=1 for 3 cycles -> wr_en_o=0, ack_o=0, ptr and contention_o unchanged; on stall_i=0 the grant resumes at the saved ptr.
- Saturation: CW=2 override with 5 contention cycles -> contention_o reaches 3 and stays at 3.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register file's single write port.
// Up to NREQ requesters compete. Each cycle, one winner is registered into a
// write transaction (wr_en_o/wr_addr_o/wr_data_o) and receives a one-cycle ack.
// A requester that is being acked this cycle is not eligible again until the
// following cycle, so it cannot win twice in a row off the same stale request.
// A saturating counter records every cycle in which two or more requesters were
// eligible while the register file was not stalled.
//
// Handshake: requester k holds req_i[k] together with its addr/data slice
// stable until it observes ack_o[k]=1. In that ack cycle it may drop the
// request or present a new one. stall_i blocks new grants only; it never
// retracts a write that is already on wr_en_o.
module regfile_wr_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 16,
   parameter int AW   = 3,
   parameter int CW   = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NREQ-1:0]      req_i,
   input  logic [NREQ*AW-1:0]   addr_i,
   input  logic [NREQ*DW-1:0]   data_i,
   input  logic                 stall_i,
   output logic [NREQ-1:0]      ack_o,
   output logic                 wr_en_o,
   output logic [AW-1:0]        wr_addr_o,
   output logic [DW-1:0]        wr_data_o,
   output logic [CW-1:0]        contention_o
);

   // Pointer width; a 2-requester arbiter still needs one pointer bit.
   localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] ack_q, ack_d;
   logic            wr_en_q, wr_en_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [DW-1:0]   wr_data_q, wr_data_d;
   logic [CW-1:0]   contention_q, contention_d;
   logic [PW-1:0]   ptr_q, ptr_d;

   logic [NREQ-1:0] elig;
   logic [PW-1:0]   win;
   logic            win_vld;
   logic [PW-1:0]   hi_win;
   logic            hi_vld;
   logic [PW-1:0]   lo_win;
   logic            lo_vld;
   logic            multi_elig;
   int              elig_cnt;
   logic            grant;

   // Requesters being acked right now are excluded from this cycle's search.
   always_comb begin
      elig = req_i & ~ack_q;
   end

   // Round-robin pick: lowest eligible index at or above ptr, else lowest overall.
   always_comb begin
      hi_win = '0;
      hi_vld = 1'b0;
      lo_win = '0;
      lo_vld = 1'b0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (elig[j]) begin
            lo_vld = 1'b1;
            lo_win = PW'(j);
            if (j >= int'(ptr_q)) begin
               hi_vld = 1'b1;
               hi_win = PW'(j);
            end
         end
      end
      win_vld = lo_vld;
      win     = hi_vld ? hi_win : lo_win;
   end

   // Count eligible requesters to detect contention (two or more at once).
   always_comb begin
      elig_cnt = 0;
      for (int j = 0; j < NREQ; j++) begin
         if (elig[j]) begin
            elig_cnt = elig_cnt + 1;
         end
      end
      multi_elig = (elig_cnt >= 2);
   end

   // A grant happens only when someone is eligible and the register file is free.
   always_comb begin
      grant = win_vld && !stall_i;
   end

   // Next write transaction, ack pulse and pointer advance.
   always_comb begin
      wr_en_d   = 1'b0;
      ack_d     = '0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      ptr_d     = ptr_q;
      if (grant) begin
         wr_en_d    = 1'b1;
         ack_d[win] = 1'b1;
         wr_addr_d  = addr_i[int'(win)*AW +: AW];
         wr_data_d  = data_i[int'(win)*DW +: DW];
         if (int'(win) == NREQ - 1) begin
            ptr_d = '0;
         end else begin
            ptr_d = win + PW'(1);
         end
      end
   end

   // Contention counter saturates at all-ones instead of wrapping.
   always_comb begin
      contention_d = contention_q;
      if (!stall_i && multi_elig && (contention_q != {CW{1'b1}})) begin
         contention_d = contention_q + CW'(1);
      end
   end

   // State registers; reset discards any in-flight transaction immediately.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ack_q        <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         contention_q <= '0;
         ptr_q        <= '0;
      end else begin
         ack_q        <= ack_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         contention_q <= contention_d;
         ptr_q        <= ptr_d;
      end
   end

   assign ack_o        = ack_q;
   assign wr_en_o      = wr_en_q;
   assign wr_addr_o    = wr_addr_q;
   assign wr_data_o    = wr_data_q;
   assign contention_o = contention_q;

endmodule
